// File: rtl/irq_seq_pkg.sv
// Shared types and constants for the IRQ entry sequencer and PSR builders.
// The HALT state is always enumerated; its logic exists only under IRQ_HALT_WAKE_EN.
package irq_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PEND   = 3'd1,
        SAVE   = 3'd2,
        SWITCH = 3'd3,
        BRANCH = 3'd4,
        FLUSH  = 3'd5,
        HALT   = 3'd6
    } irq_state_e;

    localparam logic [4:0]  MODE_IRQ           = 5'b10010;
    localparam int          PSR_I_BIT          = 7;
    localparam int          PSR_T_BIT          = 5;
    localparam logic [31:0] DEFAULT_IRQ_VECTOR = 32'h0000_0018;

    // An IRQ is accepted only while the request is low and the I mask is clear.
    function automatic logic irq_take(input logic n_irq, input logic [31:0] psr);
        return ~n_irq & ~psr[PSR_I_BIT];
    endfunction

endpackage

// File: rtl/irq_entry_sequencer_if.sv
// Signal bundle between the IRQ entry sequencer, the interrupt controller,
// the register file and the fetch unit. master = sequencer side.
interface irq_entry_sequencer_if;

    logic        nIRQ;
    logic [31:0] cpsr;
    logic        instr_boundary;
    logic [31:0] next_pc;
    logic        int_pending;
    logic        halt_req;
    logic        flush_ack;

    logic        stall_core;
    logic        spsr_irq_we;
    logic [31:0] spsr_irq_wdata;
    logic        lr_irq_we;
    logic [31:0] lr_irq_wdata;
    logic        cpsr_we;
    logic [31:0] cpsr_wdata;
    logic        pc_we;
    logic [31:0] pc_wdata;
    logic        pipe_flush;
    logic        irq_taken;
    logic        cpu_halted;

    modport master (
        input  nIRQ, cpsr, instr_boundary, next_pc, int_pending, halt_req, flush_ack,
        output stall_core, spsr_irq_we, spsr_irq_wdata, lr_irq_we, lr_irq_wdata,
               cpsr_we, cpsr_wdata, pc_we, pc_wdata, pipe_flush, irq_taken, cpu_halted
    );

    modport slave (
        output nIRQ, cpsr, instr_boundary, next_pc, int_pending, halt_req, flush_ack,
        input  stall_core, spsr_irq_we, spsr_irq_wdata, lr_irq_we, lr_irq_wdata,
               cpsr_we, cpsr_wdata, pc_we, pc_wdata, pipe_flush, irq_taken, cpu_halted
    );

endinterface

// File: rtl/irq_psr_build.sv
// Combinational IRQ-entry CPSR builder: IRQ mode, I set, T cleared, other bits kept.
module irq_psr_build
    import irq_seq_pkg::*;
(
    input  logic [31:0] cpsr,
    output logic [31:0] irq_cpsr
);

    always_comb begin
        irq_cpsr            = cpsr;
        irq_cpsr[4:0]       = MODE_IRQ;
        irq_cpsr[PSR_I_BIT] = 1'b1;
        irq_cpsr[PSR_T_BIT] = 1'b0;
    end

endmodule

// File: rtl/irq_entry_sequencer.sv
// ARM7TDMI IRQ exception entry sequencer with optional HALT-until-interrupt
// state, compiled in when IRQ_HALT_WAKE_EN is defined.
module irq_entry_sequencer
    import irq_seq_pkg::*;
#(
    parameter logic [31:0] IRQ_VECTOR = DEFAULT_IRQ_VECTOR,
    parameter logic [31:0] LR_OFFSET  = 32'd4
)(
    input  logic                  clock,
    input  logic                  reset,
    irq_entry_sequencer_if.master bus
);

    irq_state_e  state_q, state_d;
    logic [31:0] cap_pc_q, cap_pc_d;
    logic [31:0] cap_cpsr_q, cap_cpsr_d;
    logic [31:0] irq_cpsr;
    logic        take;

    logic        stall_core_q, stall_core_d;
    logic        spsr_irq_we_q, spsr_irq_we_d;
    logic [31:0] spsr_irq_wdata_q, spsr_irq_wdata_d;
    logic        lr_irq_we_q, lr_irq_we_d;
    logic [31:0] lr_irq_wdata_q, lr_irq_wdata_d;
    logic        cpsr_we_q, cpsr_we_d;
    logic [31:0] cpsr_wdata_q, cpsr_wdata_d;
    logic        pc_we_q, pc_we_d;
    logic [31:0] pc_wdata_q, pc_wdata_d;
    logic        pipe_flush_q, pipe_flush_d;
    logic        irq_taken_q, irq_taken_d;
    logic        cpu_halted_q, cpu_halted_d;

    assign take = irq_take(bus.nIRQ, bus.cpsr);

    irq_psr_build u_psr_build (
        .cpsr     (cap_cpsr_q),
        .irq_cpsr (irq_cpsr)
    );

`ifndef IRQ_HALT_WAKE_EN
    logic unused_halt_inputs;
    assign unused_halt_inputs = bus.halt_req | bus.int_pending;
`endif

    always_comb begin
        state_d     = state_q;
        cap_pc_d    = cap_pc_q;
        cap_cpsr_d  = cap_cpsr_q;
        irq_taken_d = 1'b0;

        case (state_q)
            IDLE: begin
`ifdef IRQ_HALT_WAKE_EN
                if (bus.halt_req)
                    state_d = HALT;
                else
`endif
                if (take)
                    state_d = PEND;
            end
            // A boundary is only honoured once the core is already stalled.
            PEND: begin
                if (!take) begin
                    state_d = IDLE;
                end else if (bus.instr_boundary) begin
                    cap_pc_d   = bus.next_pc;
                    cap_cpsr_d = bus.cpsr;
                    state_d    = SAVE;
                end
            end
            SAVE:   state_d = SWITCH;
            SWITCH: state_d = BRANCH;
            BRANCH: state_d = FLUSH;
            FLUSH: begin
                if (bus.flush_ack) begin
                    state_d     = IDLE;
                    irq_taken_d = 1'b1;
                end
            end
`ifdef IRQ_HALT_WAKE_EN
            HALT: begin
                if (bus.int_pending)
                    state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        stall_core_d     = (state_d != IDLE);
        spsr_irq_we_d    = (state_d == SAVE);
        spsr_irq_wdata_d = (state_d == SAVE) ? cap_cpsr_d : 32'h0;
        lr_irq_we_d      = (state_d == SAVE);
        lr_irq_wdata_d   = (state_d == SAVE) ? (cap_pc_d + LR_OFFSET) : 32'h0;
        cpsr_we_d        = (state_d == SWITCH);
        cpsr_wdata_d     = (state_d == SWITCH) ? irq_cpsr : 32'h0;
        pc_we_d          = (state_d == BRANCH);
        pc_wdata_d       = (state_d == BRANCH) ? IRQ_VECTOR : 32'h0;
        pipe_flush_d     = (state_d == BRANCH) || (state_d == FLUSH);
        cpu_halted_d     = (state_d == HALT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= IDLE;
            cap_pc_q         <= 32'h0;
            cap_cpsr_q       <= 32'h0;
            stall_core_q     <= 1'b0;
            spsr_irq_we_q    <= 1'b0;
            spsr_irq_wdata_q <= 32'h0;
            lr_irq_we_q      <= 1'b0;
            lr_irq_wdata_q   <= 32'h0;
            cpsr_we_q        <= 1'b0;
            cpsr_wdata_q     <= 32'h0;
            pc_we_q          <= 1'b0;
            pc_wdata_q       <= 32'h0;
            pipe_flush_q     <= 1'b0;
            irq_taken_q      <= 1'b0;
            cpu_halted_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            cap_pc_q         <= cap_pc_d;
            cap_cpsr_q       <= cap_cpsr_d;
            stall_core_q     <= stall_core_d;
            spsr_irq_we_q    <= spsr_irq_we_d;
            spsr_irq_wdata_q <= spsr_irq_wdata_d;
            lr_irq_we_q      <= lr_irq_we_d;
            lr_irq_wdata_q   <= lr_irq_wdata_d;
            cpsr_we_q        <= cpsr_we_d;
            cpsr_wdata_q     <= cpsr_wdata_d;
            pc_we_q          <= pc_we_d;
            pc_wdata_q       <= pc_wdata_d;
            pipe_flush_q     <= pipe_flush_d;
            irq_taken_q      <= irq_taken_d;
            cpu_halted_q     <= cpu_halted_d;
        end
    end

    assign bus.stall_core     = stall_core_q;
    assign bus.spsr_irq_we    = spsr_irq_we_q;
    assign bus.spsr_irq_wdata = spsr_irq_wdata_q;
    assign bus.lr_irq_we      = lr_irq_we_q;
    assign bus.lr_irq_wdata   = lr_irq_wdata_q;
    assign bus.cpsr_we        = cpsr_we_q;
    assign bus.cpsr_wdata     = cpsr_wdata_q;
    assign bus.pc_we          = pc_we_q;
    assign bus.pc_wdata       = pc_wdata_q;
    assign bus.pipe_flush     = pipe_flush_q;
    assign bus.irq_taken      = irq_taken_q;
    assign bus.cpu_halted     = cpu_halted_q;

endmodule

// File: tb/tb_irq_entry_sequencer.sv
// Directed self-checking bench for irq_entry_sequencer; inputs change and
// outputs are sampled on the falling clock edge.
module tb_irq_entry_sequencer;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    irq_entry_sequencer_if bus();

    irq_entry_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic logic [7:0] ctl_vec();
        return {bus.stall_core, bus.spsr_irq_we, bus.lr_irq_we, bus.cpsr_we,
                bus.pc_we, bus.pipe_flush, bus.irq_taken, bus.cpu_halted};
    endfunction

    function automatic logic [31:0] data_or();
        return bus.spsr_irq_wdata | bus.lr_irq_wdata | bus.cpsr_wdata | bus.pc_wdata;
    endfunction

    task automatic reset_check(input string tag);
        reset = 1'b1;
        tick();
        check_val({tag, "_ctl"}, {24'h0, ctl_vec()}, 32'h0);
        check_val({tag, "_data"}, data_or(), 32'h0);
        reset = 1'b0;
        tick();
        check_val({tag, "_idle"}, {24'h0, ctl_vec()}, 32'h0);
    endtask

    // abort: 0 = full entry, 1 = reset while in SAVE, 2 = reset while in FLUSH
    task automatic run_entry(input logic [31:0] cpsr_v, input logic [31:0] pc_v,
                             input logic [31:0] exp_spsr, input logic [31:0] exp_lr,
                             input logic [31:0] exp_cpsr, input logic early_bnd,
                             input int abort);
        bus.cpsr           = cpsr_v;
        bus.next_pc        = pc_v;
        bus.nIRQ           = 1'b0;
        bus.instr_boundary = early_bnd;
        tick();
        check_val("pend_stall", {31'h0, bus.stall_core}, 32'h1);
        check_val("pend_quiet", {28'h0, bus.spsr_irq_we, bus.lr_irq_we, bus.cpsr_we, bus.pc_we}, 32'h0);
        bus.instr_boundary = 1'b1;
        tick();
        bus.instr_boundary = 1'b0;
        bus.next_pc        = 32'hDEAD_BEEF;
        bus.nIRQ           = 1'b1;
        bus.cpsr           = 32'h0000_0080;
        check_val("save_we", {30'h0, bus.spsr_irq_we, bus.lr_irq_we}, 32'h3);
        check_val("spsr_wdata", bus.spsr_irq_wdata, exp_spsr);
        check_val("lr_wdata", bus.lr_irq_wdata, exp_lr);
        check_val("save_no_cpsr", {31'h0, bus.cpsr_we}, 32'h0);
        if (abort == 1) begin
            reset_check("rst_save");
            return;
        end
        tick();
        check_val("switch_we", {29'h0, bus.cpsr_we, bus.spsr_irq_we, bus.pc_we}, 32'h4);
        check_val("cpsr_wdata", bus.cpsr_wdata, exp_cpsr);
        tick();
        check_val("branch_ctl", {29'h0, bus.pc_we, bus.pipe_flush, bus.cpsr_we}, 32'h6);
        check_val("pc_wdata", bus.pc_wdata, 32'h0000_0018);
        bus.flush_ack = 1'b1;
        tick();
        check_val("flush_ctl", {28'h0, bus.stall_core, bus.pipe_flush, bus.pc_we, bus.irq_taken}, 32'hC);
        if (abort == 2) begin
            bus.flush_ack = 1'b0;
            reset_check("rst_flush");
            return;
        end
        tick();
        bus.flush_ack = 1'b0;
        check_val("taken", {29'h0, bus.irq_taken, bus.stall_core, bus.pipe_flush}, 32'h4);
        tick();
        check_val("taken_pulse", {30'h0, bus.irq_taken, bus.stall_core}, 32'h0);
    endtask

    initial begin
        logic [7:0] acc;
        n_cmp              = 0;
        n_err              = 0;
        reset              = 1'b1;
        bus.nIRQ           = 1'b1;
        bus.cpsr           = 32'h0;
        bus.instr_boundary = 1'b0;
        bus.next_pc        = 32'h0;
        bus.int_pending    = 1'b0;
        bus.halt_req       = 1'b0;
        bus.flush_ack      = 1'b0;
        repeat (3) tick();
        check_val("reset_ctl", {24'h0, ctl_vec()}, 32'h0);
        check_val("reset_data", data_or(), 32'h0);
        reset = 1'b0;
        tick();

        // ARM state entry, then Thumb entry with a boundary offered too early
        run_entry(32'h0000_001F, 32'h0800_0100, 32'h0000_001F, 32'h0800_0104, 32'h0000_0092, 1'b0, 0);
        run_entry(32'h0000_003F, 32'h0800_0202, 32'h0000_003F, 32'h0800_0206, 32'h0000_0092, 1'b1, 0);
        // Flags preserved, LR wraps modulo 2^32
        run_entry(32'h4000_0033, 32'hFFFF_FFFE, 32'h4000_0033, 32'h0000_0002, 32'h4000_0092, 1'b0, 0);

        // I bit set: request must be ignored
        bus.cpsr = 32'h0000_009F;
        bus.nIRQ = 1'b0;
        acc      = 8'h0;
        for (int i = 0; i < 50; i++) begin
            bus.instr_boundary = i[0];
            tick();
            acc = acc | ctl_vec();
        end
        bus.instr_boundary = 1'b0;
        bus.nIRQ           = 1'b1;
        check_val("ibit_quiet", {24'h0, acc}, 32'h0);

        // Withdraw while pending
        bus.cpsr = 32'h0000_001F;
        bus.nIRQ = 1'b0;
        tick();
        check_val("wd_stall", {31'h0, bus.stall_core}, 32'h1);
        bus.nIRQ = 1'b1;
        tick();
        acc = ctl_vec();
        repeat (4) begin
            tick();
            acc = acc | ctl_vec();
        end
        check_val("wd_quiet", {24'h0, acc}, 32'h0);

        // Reset in SAVE and in FLUSH, each followed by a normal entry
        run_entry(32'hA000_0010, 32'h0000_1000, 32'hA000_0010, 32'h0000_1004, 32'hA000_0092, 1'b0, 1);
        run_entry(32'hA000_0010, 32'h0000_1000, 32'hA000_0010, 32'h0000_1004, 32'hA000_0092, 1'b0, 2);
        run_entry(32'hA000_0010, 32'h0000_1000, 32'hA000_0010, 32'h0000_1004, 32'hA000_0092, 1'b0, 0);

`ifdef IRQ_HALT_WAKE_EN
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        check_val("halt_enter", {30'h0, bus.cpu_halted, bus.stall_core}, 32'h3);
        tick();
        check_val("halt_hold", {31'h0, bus.cpu_halted}, 32'h1);
        bus.cpsr        = 32'h0000_009F;
        bus.nIRQ        = 1'b0;
        bus.int_pending = 1'b1;
        tick();
        check_val("halt_wake", {30'h0, bus.cpu_halted, bus.stall_core}, 32'h0);
        acc = 8'h0;
        repeat (3) begin
            tick();
            acc = acc | ctl_vec();
        end
        check_val("wake_no_entry", {24'h0, acc}, 32'h0);
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        check_val("halt_pend_in", {31'h0, bus.cpu_halted}, 32'h1);
        tick();
        check_val("halt_pend_out", {31'h0, bus.cpu_halted}, 32'h0);
        bus.int_pending = 1'b0;
        bus.nIRQ        = 1'b1;
        tick();
`else
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        check_val("halt_ignored", {30'h0, bus.cpu_halted, bus.stall_core}, 32'h0);
        tick();
        check_val("halt_ignored2", {30'h0, bus.cpu_halted, bus.stall_core}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_entry_sequencer.md
Name: irq_entry_sequencer

Overview:
- CPU-side responder to the interrupt controller's registered, active-low nIRQ line.
- Waits for an instruction boundary, then performs ARM7TDMI IRQ exception entry:
  - save CPSR to SPSR_irq
  - write LR_irq
  - switch CPSR to IRQ mode with I=1, T=0
  - load PC with vector 0x0000_0018
  - flush the pipeline
- Sits between the interrupt controller and the core's register file and fetch unit. Also owns the optional HALT-until-interrupt state.

Parameters:
- IRQ_VECTOR, 32'h0000_0018, PC loaded on entry
- LR_OFFSET, 32'd4, added to next_pc to form LR_irq

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- nIRQ  in  1  active-low request from the interrupt controller (already registered)
- cpsr  in  32  current CPSR; bit 7 = I, bit 5 = T, [4:0] = mode
- instr_boundary  in  1  core retires an instruction this cycle; next_pc valid
- next_pc  in  32  address of the first instruction not yet executed
- int_pending  in  1  |(IE & IF) from the interrupt controller, not gated by IME
- halt_req  in  1  one-cycle pulse on HALTCNT write
- flush_ack  in  1  fetch unit has completed the flush
- stall_core  out  1  core must not retire instructions
- spsr_irq_we  out  1  write strobe, SPSR_irq bank
- spsr_irq_wdata  out  32  value written to SPSR_irq
- lr_irq_we  out  1  write strobe, R14_irq bank
- lr_irq_wdata  out  32  value written to R14_irq
- cpsr_we  out  1  CPSR write strobe
- cpsr_wdata  out  32  new CPSR value
- pc_we  out  1  PC load strobe
- pc_wdata  out  32  new PC value
- pipe_flush  out  1  flush request to fetch/decode
- irq_taken  out  1  one-cycle pulse when entry completes
- cpu_halted  out  1  core is in HALT

Behaviour:
- Reset:
  - state = IDLE
  - all outputs 0; all wdata outputs 32'h0
- take = ~nIRQ & ~cpsr[7], evaluated every cycle.
- IDLE:
  - if take, go to PEND and assert stall_core from the next cycle.
  - halt_req (feature enabled) is checked before take: halt_req -> HALT.
- PEND (stall_core=1):
  - if ~take (request withdrawn or I set), return to IDLE and drop stall.
  - else, on instr_boundary, capture next_pc and cpsr, then go to SAVE.
  - instr_boundary in the same cycle as the IDLE->PEND transition is not used; the core must present a boundary while stalled.
- SAVE, one cycle:
  - spsr_irq_we=1, spsr_irq_wdata = captured cpsr
  - lr_irq_we=1, lr_irq_wdata = captured next_pc + LR_OFFSET, modulo 2^32
- SWITCH, one cycle:
  - cpsr_we=1
  - cpsr_wdata = captured cpsr with [4:0]=5'b10010, bit 7=1, bit 5=0; all other bits unchanged
- BRANCH, one cycle:
  - pc_we=1, pc_wdata=IRQ_VECTOR, pipe_flush=1
- FLUSH (pipe_flush held 1, stall_core=1):
  - wait for flush_ack, then pulse irq_taken and go to IDLE with stall_core=0.
  - flush_ack in the same cycle BRANCH is entered is ignored.
- Commitment: once SAVE is entered the sequence always completes. Changes to nIRQ or cpsr are ignored until back in IDLE.
- Strobes are registered outputs, 1 cycle wide, and mutually exclusive except that SAVE asserts two.
- Minimum latency from boundary cycle to pc_we: 3 cycles.
- Reset in any state returns to IDLE next cycle, with all strobes deasserted immediately after that edge.

Optional Feature:
- Macro: IRQ_HALT_WAKE_EN
- Enabled:
  - HALT state entered from IDLE on halt_req; cpu_halted=1, stall_core=1.
  - Exit to IDLE when int_pending=1, regardless of IME and I bit. If take is then true, the normal PEND path follows.
  - halt_req while int_pending=1 still enters HALT and exits the next cycle.
- Disabled:
  - halt_req ignored; cpu_halted tied to 0; HALT state not compiled.

Decomposition:
- Shared package irq_seq_pkg holds:
  - state enum: IDLE, PEND, SAVE, SWITCH, BRANCH, FLUSH, HALT
  - constants: MODE_IRQ=5'b10010, PSR_I_BIT=7, PSR_T_BIT=5, default vector
- Sub-module irq_psr_build: combinational; takes cpsr and returns the IRQ-entry CPSR value. Reusable for FIQ/SWI entry later.

Test Plan:
- cpsr=32'h0000_001F, nIRQ low, boundary with next_pc=32'h0800_0100 -> spsr_irq_wdata=32'h0000_001F; lr_irq_wdata=32'h0800_0104; cpsr_wdata=32'h0000_0092; pc_wdata=32'h18; irq_taken after flush_ack.
- Thumb: cpsr=32'h0000_003F, next_pc=32'h0800_0202 -> cpsr_wdata=32'h0000_0092 (T cleared); lr_irq_wdata=32'h0800_0206.
- I-bit: cpsr[7]=1 with nIRQ low for 50 cycles -> no strobes, stall_core stays 0.
- Withdraw: nIRQ low then high while in PEND with no boundary -> back to IDLE, stall drops, no strobes.
- Reset asserted in FLUSH and in SAVE -> next cycle IDLE, all outputs 0; a new request after that is serviced normally.
- With IRQ_HALT_WAKE_EN:
  - halt_req -> cpu_halted=1.
  - int_pending=1 with cpsr[7]=1 -> cpu_halted=0 next cycle, no entry.
  - Without the macro, halt_req produces no effect.
